// File: rtl/id_ex_stage_pkg.sv
// Shared constants and the ID/EX register layout for the EX-stage front end.
package id_ex_stage_pkg;

  localparam int unsigned XLEN = 32;

  // ALU opcode encoding
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOP  = ALU_ADD;

  localparam logic [1:0] AluSrcARs1  = 2'd0;
  localparam logic [1:0] AluSrcAPc   = 2'd1;
  localparam logic [1:0] AluSrcAZero = 2'd2;

  localparam logic [1:0] AluSrcBRs2   = 2'd0;
  localparam logic [1:0] AluSrcBImm   = 2'd1;
  localparam logic [1:0] AluSrcBFour  = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1addr;
    logic [4:0]      rs2addr;
    logic [4:0]      rdaddr;
    logic [3:0]      alucode;
    logic [1:0]      alusrc_a;
    logic [1:0]      alusrc_b;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
  } ex_regs_t;

  // A bubble is indistinguishable from the reset state.
  localparam ex_regs_t ExBubble = '{
    valid:    1'b0,
    pc:       '0,
    rs1data:  '0,
    rs2data:  '0,
    imm:      '0,
    rs1addr:  '0,
    rs2addr:  '0,
    rdaddr:   '0,
    alucode:  ALU_NOP,
    alusrc_a: '0,
    alusrc_b: '0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forwarding: EX/MEM beats MEM/WB, x0 never forwarded.
module id_ex_stage_fwd_sel #(
  parameter int unsigned Width = 32
) (
  input  logic [4:0]       rs_addr_i,
  input  logic [Width-1:0] rs_data_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       mem_rdaddr_i,
  input  logic [Width-1:0] mem_result_i,
  input  logic             wb_regwrite_i,
  input  logic [4:0]       wb_rdaddr_i,
  input  logic [Width-1:0] wb_data_i,
  output logic [Width-1:0] fwd_data_o
);

  logic mem_hit, wb_hit;

  assign mem_hit = mem_regwrite_i && (mem_rdaddr_i != 5'd0) && (mem_rdaddr_i == rs_addr_i);
  assign wb_hit  = wb_regwrite_i && (wb_rdaddr_i != 5'd0) && (wb_rdaddr_i == rs_addr_i);

  always_comb begin
    fwd_data_o = rs_data_i;
    if (mem_hit) begin
      fwd_data_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, WB write-through and
// EX-stage operand forwarding/selection.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1data,
  input  logic [XLEN-1:0] id_rs2data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1addr,
  input  logic [4:0]      id_rs2addr,
  input  logic [4:0]      id_rdaddr,
  input  logic [3:0]      id_alucode,
  input  logic [1:0]      id_alusrc_a,
  input  logic [1:0]      id_alusrc_b,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rdaddr,
  input  logic [XLEN-1:0] mem_aluresult,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rdaddr,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rdaddr,
  output logic [3:0]      ex_alucode,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [XLEN-1:0] ex_store_data
);

  ex_regs_t        ex_q, ex_d, id_fields;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  function automatic logic wb_hits(input logic [4:0] addr);
    return wb_regwrite && (wb_rdaddr != 5'd0) && (wb_rdaddr == addr);
  endfunction

  assign load_use = ex_q.memread && ex_q.valid && (ex_q.rdaddr != 5'd0) && id_valid &&
                    ((id_rs1addr == ex_q.rdaddr) || (id_rs2addr == ex_q.rdaddr));

  always_comb begin
    id_fields = '{
      valid:    id_valid,
      pc:       id_pc,
      rs1data:  id_rs1data,
      rs2data:  id_rs2data,
      imm:      id_imm,
      rs1addr:  id_rs1addr,
      rs2addr:  id_rs2addr,
      rdaddr:   id_rdaddr,
      alucode:  id_alucode,
      alusrc_a: id_alusrc_a,
      alusrc_b: id_alusrc_b,
      regwrite: id_regwrite,
      memread:  id_memread,
      memwrite: id_memwrite,
      memtoreg: id_memtoreg
    };
  end

  // Priority: flush > stall > load_use > capture. The register file write in WB
  // lands this same edge, so stored operands must pick it up directly.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = ExBubble;
    end else if (stall) begin
      if (wb_hits(ex_q.rs1addr)) ex_d.rs1data = wb_data;
      if (wb_hits(ex_q.rs2addr)) ex_d.rs2data = wb_data;
    end else if (load_use) begin
      ex_d = ExBubble;
    end else begin
      ex_d = id_fields;
      if (wb_hits(id_rs1addr)) ex_d.rs1data = wb_data;
      if (wb_hits(id_rs2addr)) ex_d.rs2data = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= ExBubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  id_ex_stage_fwd_sel #(.Width(XLEN)) u_fwd_rs1 (
    .rs_addr_i      (ex_q.rs1addr),
    .rs_data_i      (ex_q.rs1data),
    .mem_regwrite_i (mem_regwrite),
    .mem_rdaddr_i   (mem_rdaddr),
    .mem_result_i   (mem_aluresult),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rdaddr_i    (wb_rdaddr),
    .wb_data_i      (wb_data),
    .fwd_data_o     (rs1_fwd)
  );

  id_ex_stage_fwd_sel #(.Width(XLEN)) u_fwd_rs2 (
    .rs_addr_i      (ex_q.rs2addr),
    .rs_data_i      (ex_q.rs2data),
    .mem_regwrite_i (mem_regwrite),
    .mem_rdaddr_i   (mem_rdaddr),
    .mem_result_i   (mem_aluresult),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rdaddr_i    (wb_rdaddr),
    .wb_data_i      (wb_data),
    .fwd_data_o     (rs2_fwd)
  );

  always_comb begin
    ex_alu_a = '0;
    case (ex_q.alusrc_a)
      AluSrcARs1:  ex_alu_a = rs1_fwd;
      AluSrcAPc:   ex_alu_a = ex_q.pc;
      AluSrcAZero: ex_alu_a = '0;
      default:     ex_alu_a = '0;
    endcase
  end

  always_comb begin
    ex_alu_b = '0;
    case (ex_q.alusrc_b)
      AluSrcBRs2:  ex_alu_b = rs2_fwd;
      AluSrcBImm:  ex_alu_b = ex_q.imm;
      AluSrcBFour: ex_alu_b = XLEN'(4);
      default:     ex_alu_b = '0;
    endcase
  end

  assign ex_store_data = rs2_fwd;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_pc         = ex_q.pc;
  assign ex_rdaddr     = ex_q.rdaddr;
  assign ex_alucode    = ex_q.alucode;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural model of the EX-stage instruction slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1data, id_rs2data, id_imm;
  logic [4:0]  id_rs1addr, id_rs2addr, id_rdaddr;
  logic [3:0]  id_alucode;
  logic [1:0]  id_alusrc_a, id_alusrc_b;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rdaddr, wb_rdaddr;
  logic [31:0] mem_aluresult, wb_data;
  logic        load_use, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [31:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [4:0]  ex_rdaddr;
  logic [3:0]  ex_alucode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
    .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr), .id_rdaddr(id_rdaddr),
    .id_alucode(id_alucode), .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .mem_regwrite(mem_regwrite), .mem_rdaddr(mem_rdaddr),
    .mem_aluresult(mem_aluresult), .wb_regwrite(wb_regwrite), .wb_rdaddr(wb_rdaddr),
    .wb_data(wb_data), .load_use(load_use), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_pc(ex_pc), .ex_rdaddr(ex_rdaddr), .ex_alucode(ex_alucode), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data)
  );

  // The instruction currently sitting in EX; known=0 when it is a bubble whose
  // data fields are not defined by the design's contract.
  typedef struct {
    bit          known;
    bit          v, rw, mr, mw, mt;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1a, r2a, rd;
    logic [3:0]  alu;
    logic [1:0]  sa, sb;
  } slot_t;

  slot_t m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input bit we, input logic [4:0] rd, input logic [4:0] rs);
    return we && rd != 5'd0 && rd == rs;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] stored);
    if (writes(mem_regwrite, mem_rdaddr, rs)) return mem_aluresult;
    if (writes(wb_regwrite, wb_rdaddr, rs)) return wb_data;
    return stored;
  endfunction

  function automatic bit exp_load_use();
    return m.v && m.mr && m.rd != 5'd0 && id_valid &&
           (id_rs1addr == m.rd || id_rs2addr == m.rd);
  endfunction

  task automatic check_outputs();
    logic [31:0] ea, eb;
    check_eq("load_use", 32'(load_use), 32'(exp_load_use()));
    check_eq("ex_valid", 32'(ex_valid), 32'(m.v));
    check_eq("ex_regwrite", 32'(ex_regwrite), 32'(m.rw));
    check_eq("ex_memread", 32'(ex_memread), 32'(m.mr));
    check_eq("ex_memwrite", 32'(ex_memwrite), 32'(m.mw));
    check_eq("ex_memtoreg", 32'(ex_memtoreg), 32'(m.mt));
    check_eq("ex_rdaddr", 32'(ex_rdaddr), 32'(m.rd));
    check_eq("ex_alucode", 32'(ex_alucode), 32'(m.alu));
    if (m.known) begin
      ea = (m.sa == 2'd0) ? fwd(m.r1a, m.r1d) : (m.sa == 2'd1) ? m.pc : 32'd0;
      eb = (m.sb == 2'd0) ? fwd(m.r2a, m.r2d) : (m.sb == 2'd1) ? m.imm :
           (m.sb == 2'd2) ? 32'd4 : 32'd0;
      check_eq("ex_pc", ex_pc, m.pc);
      check_eq("ex_alu_a", ex_alu_a, ea);
      check_eq("ex_alu_b", ex_alu_b, eb);
      check_eq("ex_store_data", ex_store_data, fwd(m.r2a, m.r2d));
    end
  endtask

  task automatic model_edge();
    bit lu;
    lu = exp_load_use();
    if (reset) begin
      m = '{known: 1'b1, default: '0};
    end else if (flush || (!stall && lu)) begin
      m.known = 0; m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.mt = 0;
      m.alu = 4'b0000; m.rd = 5'd0;
    end else if (stall) begin
      if (writes(wb_regwrite, wb_rdaddr, m.r1a)) m.r1d = wb_data;
      if (writes(wb_regwrite, wb_rdaddr, m.r2a)) m.r2d = wb_data;
    end else begin
      m.known = 1; m.v = id_valid; m.pc = id_pc; m.imm = id_imm;
      m.r1a = id_rs1addr; m.r2a = id_rs2addr; m.rd = id_rdaddr;
      m.r1d = writes(wb_regwrite, wb_rdaddr, id_rs1addr) ? wb_data : id_rs1data;
      m.r2d = writes(wb_regwrite, wb_rdaddr, id_rs2addr) ? wb_data : id_rs2data;
      m.alu = id_alucode; m.sa = id_alusrc_a; m.sb = id_alusrc_b;
      m.rw = id_regwrite; m.mr = id_memread; m.mw = id_memwrite; m.mt = id_memtoreg;
    end
  endtask

  // Inputs are set by the caller near the falling edge; checks precede the edge.
  task automatic run_cycle();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_pc = '0; id_rs1data = '0; id_rs2data = '0; id_imm = '0;
    id_rs1addr = '0; id_rs2addr = '0; id_rdaddr = '0; id_alucode = '0;
    id_alusrc_a = '0; id_alusrc_b = '0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    mem_regwrite = 0; mem_rdaddr = '0; mem_aluresult = '0;
    wb_regwrite = 0; wb_rdaddr = '0; wb_data = '0;
  endtask

  initial begin
    m = '{known: 1'b0, default: '0};
    idle_inputs();
    reset = 1;
    @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    idle_inputs();
    #1 check_eq("reset alu_a", ex_alu_a, 32'd0);
    run_cycle();

    // Normal capture with immediate operand B
    id_valid = 1; id_alucode = 4'b0011; id_rs1addr = 5'd1; id_rs1data = 32'hF0F0;
    id_rs2addr = 5'd2; id_imm = 32'h0FF0; id_alusrc_b = 2'd1; id_rdaddr = 5'd4;
    run_cycle();
    idle_inputs();
    #1;
    check_eq("cap alu_a", ex_alu_a, 32'hF0F0);
    check_eq("cap alu_b", ex_alu_b, 32'h0FF0);
    check_eq("cap alucode", 32'(ex_alucode), 32'h3);
    run_cycle();

    // Double forward, EX/MEM priority, then x0
    id_valid = 1; id_rs1addr = 5'd5; id_rs1data = 32'h99;
    run_cycle();
    idle_inputs();
    mem_regwrite = 1; mem_rdaddr = 5'd5; mem_aluresult = 32'h11;
    wb_regwrite = 1; wb_rdaddr = 5'd5; wb_data = 32'h22;
    #1 check_eq("fwd mem", ex_alu_a, 32'h11);
    mem_regwrite = 0;
    #1 check_eq("fwd wb", ex_alu_a, 32'h22);
    idle_inputs();
    id_valid = 1; id_rs1addr = 5'd0;
    run_cycle();
    idle_inputs();
    mem_regwrite = 1; mem_aluresult = 32'h11; wb_regwrite = 1; wb_data = 32'h22;
    #1 check_eq("fwd x0", ex_alu_a, 32'd0);
    run_cycle();

    // Load-use: lw x7 then add using x7
    idle_inputs();
    id_valid = 1; id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_rdaddr = 5'd7;
    run_cycle();
    idle_inputs();
    id_valid = 1; id_rs1addr = 5'd1; id_rs2addr = 5'd7; id_rdaddr = 5'd8; id_regwrite = 1;
    #1 check_eq("lu asserted", 32'(load_use), 32'd1);
    run_cycle();
    #1;
    check_eq("lu bubble valid", 32'(ex_valid), 32'd0);
    check_eq("lu bubble alucode", 32'(ex_alucode), 32'd0);
    run_cycle();
    #1;
    check_eq("lu add valid", 32'(ex_valid), 32'd1);
    check_eq("lu add rd", 32'(ex_rdaddr), 32'd8);
    idle_inputs();
    run_cycle();

    // Stall with WB write-through into stored rs1
    id_valid = 1; id_rs1addr = 5'd3; id_rs1data = 32'h1111;
    run_cycle();
    idle_inputs();
    stall = 1; wb_regwrite = 1; wb_rdaddr = 5'd3; wb_data = 32'hABCD;
    for (int i = 0; i < 3; i++) run_cycle();
    idle_inputs();
    #1 check_eq("stall wt rs1", ex_alu_a, 32'hABCD);
    run_cycle();

    // Flush and stall on the same edge
    id_valid = 1; id_regwrite = 1; id_memwrite = 1; id_rdaddr = 5'd9;
    run_cycle();
    flush = 1; stall = 1;
    run_cycle();
    idle_inputs();
    #1;
    check_eq("flush regwrite", 32'(ex_regwrite), 32'd0);
    check_eq("flush memwrite", 32'(ex_memwrite), 32'd0);
    check_eq("flush valid", 32'(ex_valid), 32'd0);

    // Reset during a valid store while stalled
    id_valid = 1; id_memwrite = 1; id_pc = 32'h100; id_rs1addr = 5'd2; id_rs2addr = 5'd6;
    id_rs1data = 32'h55; id_rs2data = 32'h66; id_imm = 32'h8; id_alusrc_b = 2'd1;
    id_alucode = 4'b0010;
    run_cycle();
    stall = 1; reset = 1;
    run_cycle();
    idle_inputs();
    #1;
    check_eq("rst valid", 32'(ex_valid), 32'd0);
    check_eq("rst memwrite", 32'(ex_memwrite), 32'd0);
    check_eq("rst alucode", 32'(ex_alucode), 32'd0);
    check_eq("rst load_use", 32'(load_use), 32'd0);
    check_eq("rst pc", ex_pc, 32'd0);
    check_eq("rst alu_b", ex_alu_b, 32'd0);
    check_eq("rst store", ex_store_data, 32'd0);
    run_cycle();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1data = $urandom; id_rs2data = $urandom; id_imm = $urandom;
      id_rs1addr = 5'($urandom_range(0, 7)); id_rs2addr = 5'($urandom_range(0, 7));
      id_rdaddr = 5'($urandom_range(0, 7)); id_alucode = 4'($urandom);
      id_alusrc_a = 2'($urandom); id_alusrc_b = 2'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom);
      id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      mem_regwrite = 1'($urandom); mem_rdaddr = 5'($urandom_range(0, 7));
      mem_aluresult = $urandom;
      wb_regwrite = 1'($urandom); wb_rdaddr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the EX-stage ALU.
- Captures decoded operands and control from ID, then resolves data hazards.
- Forwards results from EX/MEM and MEM/WB into the ALU A/B operands.
- Detects load-use hazards and inserts a bubble on them; also handles external stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- ALU_NOP, 4'b0000, ALUCode loaded into the register on bubble, flush or reset (alu_add).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all EX-stage registers (downstream busy).
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction address.
- id_rs1data, id_rs2data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1addr, id_rs2addr, id_rdaddr  in  5  register indices.
- id_alucode  in  4  ALU operation (ALU opcode encoding).
- id_alusrc_a  in  2  0=rs1, 1=pc, 2=zero.
- id_alusrc_b  in  2  0=rs2, 1=imm, 2=constant 4.
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits.
- mem_regwrite  in  1  EX/MEM stage writes a register.
- mem_rdaddr  in  5  EX/MEM destination.
- mem_aluresult  in  XLEN  EX/MEM ALU result.
- wb_regwrite  in  1  MEM/WB stage writes a register.
- wb_rdaddr  in  5  MEM/WB destination.
- wb_data  in  XLEN  MEM/WB write-back value.
- load_use  out  1  combinational; IF/ID must hold this cycle.
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control.
- ex_pc  out  XLEN  registered pc.
- ex_rdaddr  out  5  registered destination.
- ex_alucode  out  4  registered ALUCode, to ALU.
- ex_alu_a, ex_alu_b  out  XLEN  forwarded, source-selected ALU operands (combinational from registers).
- ex_store_data  out  XLEN  forwarded rs2 value for stores.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; all state updates on rising clk.
- Reset: all registered fields zero, ex_alucode=ALU_NOP, all control bits 0, ex_valid=0.
- load_use:
  - Asserted when ex_memread & ex_valid & ex_rdaddr!=0 & id_valid & (id_rs1addr==ex_rdaddr | id_rs2addr==ex_rdaddr).
  - Both rs indices are compared regardless of whether the instruction uses them (conservative).
- Update priority each edge: reset > flush > stall > load_use > normal capture.
  - flush: load a bubble (ex_valid and all control 0, ex_alucode=ALU_NOP, rdaddr 0).
  - stall: hold every register, except apply the WB write-through below.
  - load_use (no stall): load a bubble.
  - normal: capture all id_* fields.
- WB write-through on capture or hold:
  - Condition: wb_regwrite & wb_rdaddr!=0 & wb_rdaddr==rsN index.
  - Effect: the stored rsN data takes wb_data instead of id_rsNdata (normal capture) or instead of the held value (stall).
- Forwarding, per operand rsN from registered state:
  - If mem_regwrite & mem_rdaddr!=0 & mem_rdaddr==rsN, use mem_aluresult.
  - Else if wb_regwrite & wb_rdaddr!=0 & wb_rdaddr==rsN, use wb_data.
  - Else use the stored data.
  - EX/MEM has priority over MEM/WB; x0 is never forwarded and always reads 0 from the register file.
- Operand select: ex_alu_a, ex_alu_b and ex_store_data are defined by the operand-select rules below. Unused encoding 3 yields 0.
  - ex_alu_a: forwarded rs1, ex_pc or 0, per the stored alusrc_a.
  - ex_alu_b: forwarded rs2, stored imm or 32'd4, per the stored alusrc_b.
  - ex_store_data is always forwarded rs2.
- Latency: one cycle from ID to EX registers; forwarding adds no cycle.
- Simultaneous events:
  - flush with stall: flush wins.
  - load_use is still reported during stall; the upstream stage must hold in either case.
  - Reset mid-stall clears everything the same cycle.

Decomposition:
- Shared package/header: ALUCode constants (ALU encodings), ALUSRC_A/B encodings, ALU_NOP, XLEN.
- One natural sub-module: fwd_sel (per-operand forwarding comparator and mux), instantiated twice (rs1, rs2).

Test Plan:
- Normal capture: id_alucode=0011, rs1data=0xF0F0, imm=0x0FF0, alusrc_b=1, no hazards -> next cycle ex_alu_a=0xF0F0, ex_alu_b=0x0FF0, ex_alucode=0011.
- Double forward: ex rs1=5; mem_rdaddr=5 (0x11), wb_rdaddr=5 (0x22), both regwrite -> ex_alu_a=0x11; drop mem_regwrite -> ex_alu_a=0x22; rs1=0 with matching rd=0 -> ex_alu_a=0.
- Load-use: EX holds lw x7 (memread=1, rd=7); ID add uses rs2=7 -> load_use=1, next cycle ex_valid=0 and ex_alucode=0000; the following cycle the add is captured.
- Stall with WB write-through: stall=1 for 3 cycles, wb writes x3=0xABCD where stored rs1=3 -> after release, the stored rs1 value is 0xABCD.
- Flush vs stall: flush=1 and stall=1 on the same edge -> bubble loaded, ex_regwrite=0, ex_memwrite=0.
- Reset mid-operation: reset=1 during a valid store -> next edge all outputs 0, ex_alucode=ALU_NOP, load_use=0.
